// File: rtl/imem_fetch_ctrl_pkg.sv
// Shared definitions for the instruction fetch controller.
package imem_fetch_ctrl_pkg;

    localparam int unsigned XLEN = 32;

    // ADDI x0, x0, 0
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/imem_fetch_ctrl.sv
// Fetch-stage controller: owns the PC, drives the instruction memory index and
// fills the IF/ID register; handles stall, redirect/flush and out-of-range halt.
module imem_fetch_ctrl
    import imem_fetch_ctrl_pkg::*;
#(
    parameter int unsigned     DEPTH    = 256,
    parameter logic [XLEN-1:0] RESET_PC = 32'd0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic [XLEN-1:0] imem_rdata_i,
    output logic [XLEN-1:0] if_id_instr_o,
    output logic [XLEN-1:0] if_id_pc_o,
    output logic            if_id_valid_o,
    output logic            fetch_fault_o,
    output logic [XLEN-1:0] fetch_count_o
);

    fetch_state_e    state;
    logic [XLEN-1:0] pc;
    logic            pc_out_of_range;

    // Memory index is the PC register itself; read data returns in the same cycle.
    assign imem_addr_o     = pc;
    assign pc_out_of_range = (pc >= XLEN'(DEPTH));

    // Fetch sequencing: redirect > range fault > stall > normal capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_BOOT;
            pc            <= RESET_PC;
            if_id_instr_o <= NOP_INSTR;
            if_id_pc_o    <= '0;
            if_id_valid_o <= 1'b0;
            fetch_fault_o <= 1'b0;
            fetch_count_o <= '0;
        end else begin
            case (state)
                ST_BOOT: begin
                    state <= ST_RUN;
                end
                ST_RUN: begin
                    if (redirect_i) begin
                        pc            <= redirect_pc_i;
                        if_id_instr_o <= NOP_INSTR;
                        if_id_valid_o <= 1'b0;
                    end else if (pc_out_of_range) begin
                        state         <= ST_HALT;
                        fetch_fault_o <= 1'b1;
                        if_id_valid_o <= 1'b0;
                    end else if (!stall_i) begin
                        if_id_instr_o <= imem_rdata_i;
                        if_id_pc_o    <= pc;
                        if_id_valid_o <= 1'b1;
                        pc            <= pc + XLEN'(1);
                        fetch_count_o <= fetch_count_o + XLEN'(1);
                    end
                end
                ST_HALT: begin
                    if_id_valid_o <= 1'b0;
                    if (redirect_i) begin
                        state         <= ST_RUN;
                        pc            <= redirect_pc_i;
                        if_id_instr_o <= NOP_INSTR;
                    end
                end
                default: begin
                    state <= ST_BOOT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Self-checking bench for imem_fetch_ctrl: directed vector table, hand-written
// fault/halt/reset sequences, then randomized traffic against a reference model.
module tb_imem_fetch_ctrl;

    localparam int unsigned DEPTH = 256;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc;
    logic        if_id_valid;
    logic        fetch_fault;
    logic [31:0] fetch_count;

    int pass_cnt = 0;
    int total_cnt = 0;

    imem_fetch_ctrl #(.DEPTH(DEPTH), .RESET_PC(32'd0)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall_i       (stall),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .imem_addr_o   (imem_addr),
        .imem_rdata_i  (imem_rdata),
        .if_id_instr_o (if_id_instr),
        .if_id_pc_o    (if_id_pc),
        .if_id_valid_o (if_id_valid),
        .fetch_fault_o (fetch_fault),
        .fetch_count_o (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory content: an ADD-opcode word tagged with its own index.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[24:0], 7'h33};
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic chk_all(input string tag, input logic e_valid, input logic [31:0] e_pc,
                           input logic [31:0] e_addr, input logic [31:0] e_count,
                           input logic [31:0] e_instr, input logic e_fault);
        chk({tag, ".valid"}, 32'(if_id_valid), 32'(e_valid));
        chk({tag, ".pc"},    if_id_pc,    e_pc);
        chk({tag, ".addr"},  imem_addr,   e_addr);
        chk({tag, ".count"}, fetch_count, e_count);
        chk({tag, ".instr"}, if_id_instr, e_instr);
        chk({tag, ".fault"}, 32'(fetch_fault), 32'(e_fault));
    endtask

    // Drive inputs after the falling edge, take one rising edge, sample at the next falling edge.
    task automatic step(input logic s, input logic r, input logic [31:0] t);
        stall = s;
        redirect = r;
        redirect_pc = t;
        @(posedge clk);
        model_edge(s, r, t);
        @(negedge clk);
    endtask

    // Reference model: what the fetch stage should look like after each edge.
    logic        m_booted, m_halted, m_valid, m_fault;
    logic [31:0] m_pc, m_ifpc, m_instr, m_count;

    task automatic model_edge(input logic s, input logic r, input logic [31:0] t);
        if (!m_booted) begin
            m_booted = 1'b1;
        end else if (r) begin
            m_pc = t;
            m_instr = NOP;
            m_valid = 1'b0;
            m_halted = 1'b0;
        end else if (m_halted) begin
            m_valid = 1'b0;
        end else if (m_pc >= DEPTH) begin
            m_halted = 1'b1;
            m_fault = 1'b1;
            m_valid = 1'b0;
        end else if (!s) begin
            m_instr = mem_word(m_pc);
            m_ifpc = m_pc;
            m_valid = 1'b1;
            m_pc = m_pc + 1;
            m_count = m_count + 1;
        end
    endtask

    task automatic model_reset();
        m_booted = 1'b0; m_halted = 1'b0; m_valid = 1'b0; m_fault = 1'b0;
        m_pc = 32'd0; m_ifpc = 32'd0; m_instr = NOP; m_count = 32'd0;
    endtask

    typedef struct {
        logic        s;
        logic        r;
        logic [31:0] t;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_addr;
        logic [31:0] e_count;
        logic [31:0] e_instr;
    } vec_t;

    vec_t tbl[20];

    function automatic vec_t mk(input logic s, input logic r, input logic [31:0] t,
                                input logic v, input logic [31:0] p, input logic [31:0] a,
                                input logic [31:0] c, input logic [31:0] i);
        vec_t x;
        x.s = s; x.r = r; x.t = t; x.e_valid = v;
        x.e_pc = p; x.e_addr = a; x.e_count = c; x.e_instr = i;
        return x;
    endfunction

    initial begin
        // Edges 1..20 after reset release
        tbl[0] = mk(0, 0, 0, 0, 0, 0, 0, NOP);                       // BOOT
        for (int k = 2; k <= 9; k++)                                 // pcs 0..7 in order
            tbl[k-1] = mk(0, 0, 0, 1, 32'(k-2), 32'(k-1), 32'(k-1), mem_word(32'(k-2)));
        tbl[9]  = mk(1, 1, 9, 0, 7, 9, 8, NOP);                      // redirect+stall at PC=8
        tbl[10] = mk(0, 0, 0, 1, 9, 10, 9, mem_word(9));
        tbl[11] = mk(1, 0, 0, 1, 9, 10, 9, mem_word(9));
        tbl[12] = mk(1, 0, 0, 1, 9, 10, 9, mem_word(9));
        tbl[13] = mk(0, 0, 0, 1, 10, 11, 10, mem_word(10));
        tbl[14] = mk(0, 1, 2, 0, 10, 2, 10, NOP);                    // redirect to 2
        tbl[15] = mk(0, 0, 0, 1, 2, 3, 11, mem_word(2));
        for (int k = 16; k <= 18; k++)                               // stall 3 cycles at PC=3
            tbl[k] = mk(1, 0, 0, 1, 2, 3, 11, mem_word(2));
        tbl[19] = mk(0, 0, 0, 1, 3, 4, 12, mem_word(3));

        stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chk_all("reset", 0, 0, 0, 0, NOP, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            step(tbl[i].s, tbl[i].r, tbl[i].t);
            chk_all($sformatf("vec%0d", i + 1), tbl[i].e_valid, tbl[i].e_pc,
                    tbl[i].e_addr, tbl[i].e_count, tbl[i].e_instr, 1'b0);
        end

        // Run up to the end of memory and fault
        step(0, 1, 250);
        chk_all("redir250", 0, 3, 250, 12, NOP, 0);
        for (int k = 0; k < 6; k++) step(0, 0, 0);
        chk_all("pc255", 1, 255, 256, 18, mem_word(255), 0);
        step(0, 0, 0);
        chk_all("fault", 0, 255, 256, 18, mem_word(255), 1);
        for (int k = 0; k < 5; k++) begin
            step(1'($urandom_range(0, 1)), 0, 0);
            chk_all($sformatf("halt%0d", k), 0, 255, 256, 18, mem_word(255), 1);
        end

        // Leave HALT by redirect (with stall ignored)
        step(1, 1, 20);
        chk_all("halt_redir", 0, 255, 20, 18, NOP, 1);
        step(0, 0, 0);
        chk_all("after_halt", 1, 20, 21, 19, mem_word(20), 1);

        // Asynchronous reset between edges
        #2 rst_n = 1'b0;
        #1 chk_all("async_rst", 0, 0, 0, 0, NOP, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 0, 0);
        chk_all("rst_boot", 0, 0, 0, 0, NOP, 0);
        step(0, 0, 0);
        chk_all("rst_first", 1, 0, 1, 1, mem_word(0), 0);

        // Randomized traffic against the reference model
        model_reset();
        m_booted = 1'b1; m_valid = 1'b1; m_pc = 1; m_ifpc = 0; m_count = 1; m_instr = mem_word(0);
        for (int n = 0; n < 400; n++) begin
            logic        s, r;
            logic [31:0] t;
            int unsigned sel;
            s = ($urandom_range(0, 3) == 0);
            r = ($urandom_range(0, 7) == 0);
            sel = $urandom_range(0, 9);
            if (sel < 6)       t = 32'($urandom_range(0, DEPTH - 1));
            else if (sel < 8)  t = 32'($urandom_range(DEPTH - 3, DEPTH + 2));
            else if (sel == 8) t = 32'hFFFF_FFFF;
            else               t = $urandom;
            step(s, r, t);
            chk_all($sformatf("rnd%0d", n), m_valid, m_ifpc, m_pc, m_count, m_instr, m_fault);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
